key_scan: RTL and testbench
===========================

// Module: key_scan
// PURPOSE
//  Scans the 4x4 calculator keypad matrix and turns one debounced key press into
//  a key code. It produces key_value[3:0] and a single-cycle flag pulse, which the
//  calculator input controller samples. The block sits between the keypad pins and
//  the input controller. It runs from the same 1 kHz clock domain.
// PARAMETERS
//  SCAN_DWELL   4   cycles each column is driven low; rows sampled on last cycle (>=3)
//  DEBOUNCE     20  consecutive stable cycles needed to accept a press or a release
// PORTS
//  CLK_1K     in   1  1 kHz system clock
//  RST        in   1  asynchronous reset, active-low
//  row_in     in   4  keypad rows from pins, active-low (pulled up), asynchronous
//  col_out    out  4  keypad column drive, one-hot active-low
//  key_value  out  4  code of the last accepted key; held until the next accept
//  flag       out  1  1-cycle pulse: key_value is new and valid this cycle
// BEHAVIOUR
//  Reset (async, RST=0): state=SCAN, col_out=4'b1110, key_value=0, flag=0,
//  counters=0, sync flops=4'b1111.
//  row_in passes through a 2-flop synchronizer. "rows" below means the synced value.
//  "Single key" means rows has exactly one bit low; 1111 or >=2 low is not a single key.
//  Key map (row r = rows bit r low, column c = col_out bit c low):
//   r0: c0=1 c1=2 c2=3 c3=a(+) | r1: 4 5 6 b(-) | r2: 7 8 9 c(*) | r3: f(clr) 0 e(=) d(/)
//  FSM:
//   SCAN: hold each column SCAN_DWELL cycles, then rotate 1110->1101->1011->0111->1110.
//     On the last dwell cycle with a single key: latch row/col, clear cnt, go to DEBOUNCE
//     and freeze col_out. Otherwise keep rotating. Multi-key patterns are ignored.
//   DEBOUNCE: col_out frozen. Each cycle, if rows equals the latched pattern, cnt++.
//     If rows differs, go to SCAN and resume at the next column (no flag).
//     When cnt reaches DEBOUNCE-1 and rows still match: register key_value=map(row,col),
//     pulse flag=1 for exactly one cycle, go to HOLD.
//   HOLD: col_out frozen, no further flags (no auto-repeat). Count cycles with rows==1111.
//     Any low row clears cnt. After DEBOUNCE consecutive all-high cycles, go to SCAN
//     at the next column.
//  Latency: a press stable from the entry edge gives flag DEBOUNCE cycles after that edge.
//  From the pin to flag adds 2 sync cycles plus up to 4*SCAN_DWELL scan cycles.
//  flag is never high on two consecutive cycles. flag=0 in SCAN and DEBOUNCE.
//  key_value changes only on the same edge that raises flag.
//  A second key pressed in HOLD is ignored until full release and the new scan.
//  A bounce during release restarts the release count; it never causes a second flag.
//  RST deasserted mid-press: restart from SCAN col0. A held key is accepted once,
//  after DEBOUNCE cycles.
//  All outputs are registered. There are no combinational paths from row_in to outputs.
// TESTING
//  1 Reset: RST=0 -> col_out=1110, key_value=0, flag=0. Release; idle rows=1111 ->
//    col_out rotates every 4 cycles, flag stays 0.
//  2 Key '5' (r1,c1) held 40 cycles -> exactly one flag pulse, key_value=4'h5.
//    No flag on release.
//  3 Bounce: '7' toggled every 3 cycles for 30 cycles, then stable -> one flag,
//    key_value=4'h7, only after 20 stable cycles.
//  4 Sequence 1,2,a,3,e (each 40 on / 40 off) -> five flags with codes 1,2,a,3,e in order.
//  5 Two keys at once (r0c0 + r2c0 low) -> no flag. Release one; the other stable -> one flag.
//  6 RST pulsed low mid-DEBOUNCE of 'd' -> outputs at reset values. Key still held ->
//    one flag with 4'hd, after a fresh scan plus debounce.

Source files
------------

// File: rtl/key_scan.sv
// key_scan: 4x4 keypad matrix scanner. Synchronizes the rows, debounces one key,
// emits its code with a one-cycle flag, then waits for a debounced release.
module key_scan #(
    parameter int SCAN_DWELL = 4,
    parameter int DEBOUNCE   = 20
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_value,
    output logic       flag
);

    localparam int DW_W  = $clog2(SCAN_DWELL);
    localparam int CNT_W = $clog2(DEBOUNCE);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

    logic [3:0]       sync1, rows;
    state_t           state, state_nxt;
    logic [3:0]       col_nxt;
    logic [DW_W-1:0]  dwell, dwell_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       row_lat, row_lat_nxt;
    logic [3:0]       key_nxt;
    logic             flag_nxt;
    logic [3:0]       col_rot;

    // Exactly one row pulled low: a single key on the driven column.
    function automatic logic single_key(input logic [3:0] r);
        case (r)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] row, input logic [3:0] col);
        logic [1:0] r;
        logic [1:0] c;
        r = 2'd0;
        c = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row[i]) r = 2'(i);
            if (!col[i]) c = 2'(i);
        end
        case ({r, c})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'ha;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hb;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'ha: return 4'h9;
            4'hb: return 4'hc;
            4'hc: return 4'hf;
            4'hd: return 4'h0;
            4'he: return 4'he;
            default: return 4'hd;
        endcase
    endfunction

    // NOTE: row_in is asynchronous to CLK_1K; two flops before any decision uses it.
    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            sync1 <= 4'b1111;
            rows  <= 4'b1111;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments.
            sync1 <= row_in;
            rows  <= sync1;
        end
    end

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            state     <= ST_SCAN;
            col_out   <= 4'b1110;
            dwell     <= '0;
            cnt       <= '0;
            row_lat   <= 4'b1111;
            key_value <= 4'h0;
            flag      <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_out   <= col_nxt;
            dwell     <= dwell_nxt;
            cnt       <= cnt_nxt;
            row_lat   <= row_lat_nxt;
            key_value <= key_nxt;
            flag      <= flag_nxt;
        end
    end

    assign col_rot = {col_out[2:0], col_out[3]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt   = state;
        col_nxt     = col_out;
        dwell_nxt   = dwell;
        cnt_nxt     = cnt;
        row_lat_nxt = row_lat;
        key_nxt     = key_value;
        flag_nxt    = 1'b0;

        case (state)
            ST_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (single_key(rows)) begin
                        state_nxt   = ST_DEBOUNCE;
                        row_lat_nxt = rows;
                        cnt_nxt     = '0;
                    end else begin
                        col_nxt = col_rot;
                    end
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (rows != row_lat) begin
                    state_nxt = ST_SCAN;
                    col_nxt   = col_rot;
                    dwell_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    key_nxt   = key_code(row_lat, col_out);
                    flag_nxt  = 1'b1;
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_HOLD: begin
                // Release must be clean for DEBOUNCE cycles; any bounce restarts it.
                if (rows != 4'b1111) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_SCAN;
                    col_nxt   = col_rot;
                    dwell_nxt = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: state_nxt = ST_SCAN;
        endcase
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad model drives row_in from col_out, a press-level
// model checks every cycle, and directed tests pin counts, codes and latency.
module tb_key_scan;

    localparam int SCAN_DWELL = 4;
    localparam int DEBOUNCE   = 20;
    localparam int MISS_BOUND = DEBOUNCE + 4 * SCAN_DWELL + 4;

    localparam logic [3:0] KEY_MAP [16] = '{4'h1, 4'h2, 4'h3, 4'ha,
                                            4'h4, 4'h5, 4'h6, 4'hb,
                                            4'h7, 4'h8, 4'h9, 4'hc,
                                            4'hf, 4'h0, 4'he, 4'hd};

    logic       CLK_1K = 1'b0;
    logic       RST    = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_value;
    logic       flag;

    logic [15:0] keys = '0;   // pressed keys, bit index = row*4 + col

    int checks = 0;
    int errors = 0;
    logic [3:0] seen[$];

    key_scan #(.SCAN_DWELL(SCAN_DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK_1K    (CLK_1K),
        .RST       (RST),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_value (key_value),
        .flag      (flag)
    );

    always #5 CLK_1K = ~CLK_1K;

    // Passive matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [15:0] k);
        for (int i = 0; i < 16; i++)
            if (k[i]) return KEY_MAP[i];
        return 4'h0;
    endfunction

    // Press-level model: a flag is legal only for a single key held steady for
    // at least DEBOUNCE cycles since the last full release; it must come within
    // MISS_BOUND cycles of the press settling.
    logic [15:0] prev_keys = '0;
    int          stable    = 0;
    int          idle      = 0;
    bit          armed     = 1'b1;
    logic [3:0]  exp_kv    = 4'h0;

    always @(negedge CLK_1K) begin
        if (!RST) begin
            check("reset_col_out", col_out, 4'b1110);
            check("reset_key_value", key_value, 4'h0);
            check("reset_flag", flag, 1'b0);
            exp_kv    = 4'h0;
            armed     = 1'b1;
            stable    = 0;
            idle      = 0;
            prev_keys = keys;
        end else begin
            if (keys != prev_keys) stable = 0;
            else if (stable < 100000) stable++;
            prev_keys = keys;
            if (keys == '0) begin
                if (idle < 100000) idle++;
            end else begin
                idle = 0;
            end
            if (idle >= DEBOUNCE) armed = 1'b1;

            check("col_one_cold", $countones(~col_out), 1);
            if (flag) begin
                seen.push_back(key_value);
                check("flag_allowed", {armed, $countones(keys) == 1, stable >= DEBOUNCE}, 3'b111);
                if (armed && $countones(keys) == 1 && stable >= DEBOUNCE) exp_kv = code_of(keys);
                armed = 1'b0;
            end
            check("key_value", key_value, exp_kv);
            if (armed && $countones(keys) == 1 && stable == MISS_BOUND)
                check("flag_missed", flag, 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK_1K);
        #1;
    endtask

    task automatic press(input int idx, input int on_cycles, input int off_cycles);
        keys = 16'(1) << idx;
        step(on_cycles);
        keys = '0;
        step(off_cycles);
    endtask

    initial begin
        logic [3:0] exp_col;
        int         first;
        int         seq_idx [5];
        logic [3:0] seq_code [5];

        seq_idx  = '{0, 1, 3, 2, 14};
        seq_code = '{4'h1, 4'h2, 4'ha, 4'h3, 4'he};

        // 1: reset values, then idle rotation every SCAN_DWELL cycles
        step(3);
        check("t1_col_out", col_out, 4'b1110);
        check("t1_key_value", key_value, 4'h0);
        check("t1_flag", flag, 1'b0);
        RST = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK_1K);
            exp_col = ~(4'b0001 << ((k / SCAN_DWELL) % 4));
            check("t1_rotate", col_out, exp_col);
        end
        #1;
        step(10);
        check("t1_no_flags", seen.size(), 0);

        // 2: key '5' held 40 cycles, no flag on release
        seen.delete();
        press(5, 40, 40);
        check("t2_flag_count", seen.size(), 1);
        if (seen.size() >= 1) check("t2_code", seen[0], 4'h5);
        check("t2_key_value", key_value, 4'h5);

        // 3: '7' bouncing every 3 cycles, then stable
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'(1) << 8 : 16'h0;
            step(3);
        end
        keys = 16'(1) << 8;
        step(DEBOUNCE - 1);
        check("t3_no_early_flag", seen.size(), 0);
        step(21);
        keys = '0;
        step(40);
        check("t3_flag_count", seen.size(), 1);
        if (seen.size() >= 1) check("t3_code", seen[0], 4'h7);

        // 4: sequence 1, 2, a, 3, e
        seen.delete();
        for (int i = 0; i < 5; i++) press(seq_idx[i], 40, 40);
        check("t4_flag_count", seen.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < seen.size()) check("t4_code", seen[i], seq_code[i]);

        // 5: two keys in one column are ignored; the survivor is accepted once
        seen.delete();
        keys = (16'(1) << 0) | (16'(1) << 8);
        step(40);
        check("t5_multi_no_flag", seen.size(), 0);
        keys = 16'(1) << 8;
        step(40);
        keys = '0;
        step(40);
        check("t5_flag_count", seen.size(), 1);
        if (seen.size() >= 1) check("t5_code", seen[0], 4'h7);

        // 6: reset pulsed during the debounce of 'd' while the key stays held
        seen.delete();
        RST  = 1'b0;
        keys = 16'(1) << 15;
        step(2);
        RST = 1'b1;
        step(26);
        check("t6_pre_no_flag", seen.size(), 0);
        RST = 1'b0;
        step(3);
        check("t6_rst_col_out", col_out, 4'b1110);
        check("t6_rst_key_value", key_value, 4'h0);
        check("t6_rst_flag", flag, 1'b0);
        RST   = 1'b1;
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK_1K);
            if (flag && first == 0) first = k;
        end
        #1;
        check("t6_flag_latency", first, 12 + SCAN_DWELL + DEBOUNCE);
        check("t6_key_value", key_value, 4'hd);
        keys = '0;
        step(40);
        check("t6_flag_count", seen.size(), 1);

        // 7: every key of the matrix once
        seen.delete();
        for (int i = 0; i < 16; i++) press(i, 45, 40);
        check("t7_flag_count", seen.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < seen.size()) check("t7_code", seen[i], KEY_MAP[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
